// File: rtl/fp_divider.sv
// fp_divider -- IEEE-754 single-precision divider, out = a / b.
//
// Multi-cycle unit built from a small FSM and a restoring divider that
// produces one quotient bit per cycle. Results are truncated toward zero.
// Denormal inputs are normalised before dividing. Results never come out
// as denormals: a result that underflows is flushed to signed zero, and a
// result that overflows becomes signed infinity. NaN, zero and infinity
// operands skip the divider and complete two cycles after acceptance.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands a, b presented
//   in_ready     block idle and able to accept operands
//   a, b         IEEE-754 single dividend / divisor
//   out_valid    quotient available (held until out_ready)
//   out_ready    consumer accepts quotient
//   out          IEEE-754 single quotient
//   div_by_zero  finite nonzero a divided by zero, qualified by out_valid
module fp_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        div_by_zero
);

   localparam logic [31:0] QNAN  = 32'h7FC0_0000;
   localparam int          ITERS = 26;

   typedef enum logic [2:0] {IDLE, PREP, DIV, NORM, DONE} state_t;

   state_t             state;
   state_t             state_nxt;

   logic [31:0]        a_reg;
   logic [31:0]        b_reg;
   logic [25:0]        rem;
   logic [25:0]        quo;
   logic [23:0]        divisor;
   logic [4:0]         cnt;
   logic signed [9:0]  exp_w;
   logic               sign_r;
   logic [31:0]        out_r;
   logic               dbz_r;

   // Leading-zero count of a 24-bit mantissa (only meaningful when nonzero).
   function automatic logic [4:0] lzc24(input logic [23:0] m);
      lzc24 = 5'd0;
      for (int i = 0; i < 24; i++) begin
         if (m[i]) lzc24 = 5'(23 - i);
      end
   endfunction

   // Assemble the result, saturating to infinity or flushing to zero.
   function automatic logic [31:0] pack(input logic s,
                                        input logic signed [9:0] e,
                                        input logic [22:0] m);
      if (e >= 10'sd255)
         pack = {s, 8'hFF, 23'd0};
      else if (e <= 10'sd0)
         pack = {s, 31'd0};
      else
         pack = {s, e[7:0], m};
   endfunction

   // ---------------------------------------------------------------
   // Operand decode / normalisation (consumed in PREP)
   // ---------------------------------------------------------------
   logic [7:0]         ea_f, eb_f;
   logic [23:0]        ma_raw, mb_raw, ma_n, mb_n;
   logic [4:0]         sh_a, sh_b;
   logic signed [9:0]  ea_n, eb_n, exp_init;
   logic               sign_c;
   logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic               spec_nan, special, spec_dbz;
   logic [31:0]        spec_out;

   assign ea_f   = a_reg[30:23];
   assign eb_f   = b_reg[30:23];
   assign ma_raw = {ea_f != 8'd0, a_reg[22:0]};
   assign mb_raw = {eb_f != 8'd0, b_reg[22:0]};
   assign sh_a   = lzc24(ma_raw);
   assign sh_b   = lzc24(mb_raw);
   assign ma_n   = ma_raw << sh_a;
   assign mb_n   = mb_raw << sh_b;

   // Exponent field 0 behaves as exponent 1; normalising shifts lower it.
   assign ea_n = $signed({2'b00, (ea_f == 8'd0) ? 8'd1 : ea_f}) - $signed({5'd0, sh_a});
   assign eb_n = $signed({2'b00, (eb_f == 8'd0) ? 8'd1 : eb_f}) - $signed({5'd0, sh_b});
   assign exp_init = ea_n - eb_n + 10'sd127;

   assign sign_c = a_reg[31] ^ b_reg[31];
   assign a_nan  = (&a_reg[30:23]) &  (|a_reg[22:0]);
   assign a_inf  = (&a_reg[30:23]) & ~(|a_reg[22:0]);
   assign a_zero = ~(|a_reg[30:0]);
   assign b_nan  = (&b_reg[30:23]) &  (|b_reg[22:0]);
   assign b_inf  = (&b_reg[30:23]) & ~(|b_reg[22:0]);
   assign b_zero = ~(|b_reg[30:0]);

   assign spec_nan = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
   assign special  = spec_nan | a_inf | b_inf | b_zero | a_zero;

   // Special-case result; order of the tests sets priority.
   always_comb begin
      spec_out = {sign_c, 31'd0};
      spec_dbz = 1'b0;
      if (spec_nan)
         spec_out = QNAN;
      else if (a_inf)
         spec_out = {sign_c, 8'hFF, 23'd0};
      else if (b_inf)
         spec_out = {sign_c, 31'd0};
      else if (b_zero) begin
         spec_out = {sign_c, 8'hFF, 23'd0};
         spec_dbz = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Restoring division step and final normalisation
   // ---------------------------------------------------------------
   logic               rem_ge;
   logic [25:0]        rem_sel, rem_nxt;
   logic [22:0]        norm_mant;
   logic signed [9:0]  norm_exp;

   assign rem_ge    = rem >= {2'b00, divisor};
   assign rem_sel   = rem_ge ? (rem - {2'b00, divisor}) : rem;
   assign rem_nxt   = rem_sel << 1;

   // Quotient lies in (2^24, 2^26): the leading one is at bit 25 or 24.
   assign norm_mant = quo[25] ? quo[24:2] : quo[23:1];
   assign norm_exp  = quo[25] ? exp_w : exp_w - 10'sd1;

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = PREP;
         end
         PREP:    state_nxt = special ? DONE : DIV;
         DIV:     if (cnt == 5'(ITERS - 1)) state_nxt = NORM;
         NORM:    state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         cnt     <= '0;
         exp_w   <= '0;
         sign_r  <= 1'b0;
         out_r   <= '0;
         dbz_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
               end
            end
            PREP: begin
               sign_r  <= sign_c;
               exp_w   <= exp_init;
               rem     <= {2'b00, ma_n};
               divisor <= mb_n;
               quo     <= '0;
               cnt     <= '0;
               if (special) begin
                  out_r <= spec_out;
                  dbz_r <= spec_dbz;
               end
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= {quo[24:0], rem_ge};
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               out_r <= pack(sign_r, norm_exp, norm_mant);
               dbz_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out         = out_r;
   assign div_by_zero = dbz_r;

endmodule
